adder45_rr_arbiter: RTL and testbench
=====================================

# adder45_rr_arbiter

Round-robin arbiter and sequencer that shares a single 45-bit + 41-bit unsigned adder (`customAdder45_4`) between `NUM_REQ` requesters in the multiply/accumulate datapath. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers the operands, and registers the 46-bit sum. It returns the sum with the requester's ID through a single-entry response buffer with valid/ready back-pressure.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal values 2–8.
- `ID_W`, `$clog2(NUM_REQ)`: width of `rsp_id`; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `NUM_REQ`: bit i = requester i holds a valid operand pair.
- `req_a` in `NUM_REQ*45`: requester i operand A at bits `[45*i+44 : 45*i]`.
- `req_b` in `NUM_REQ*41`: requester i operand B at bits `[41*i+40 : 41*i]`.
- `req_ready` out `NUM_REQ`: one-hot or zero; bit i = requester i's operands are taken this cycle.
- `rsp_valid` out 1: `rsp_sum` and `rsp_id` are valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `ID_W`: index of the requester that owns `rsp_sum`.
- `rsp_sum` out 46: A + zero-extended B.

## Operation
- Arithmetic: `rsp_sum = {1'b0, A} + {5'b0, B}`. The full 46-bit result is kept, so there is never overflow or truncation. The add is done by one instance of `customAdder45_4` fed from the operand registers.
- State machine:
  - IDLE: no operation in flight.
  - EXEC: operand registers loaded; the sum is registered at the end of this cycle.
  - RESP: `rsp_valid` = 1, waiting for `rsp_ready`.
- A grant is possible ("grant window") in IDLE, or in RESP when `rsp_ready` = 1.
- Arbitration in a grant window:
  - Search `req_valid` starting at priority pointer `ptr`, ascending with wrap; the first set bit is the winner w.
  - Assert `req_ready[w]` combinationally in the same cycle.
  - Load `opA`/`opB`/`id` registers with requester w's operands; set `ptr <= (w+1) mod NUM_REQ`.
  - Next state is EXEC.
- Transitions:
  - IDLE, no `req_valid` set: stay IDLE; `req_ready` = 0.
  - EXEC → RESP, unconditionally. `sum_reg <= adder output`, `rsp_id <= id`.
  - RESP, `rsp_ready` = 0: hold. `rsp_sum`/`rsp_id` stay stable; `req_ready` = 0.
  - RESP, `rsp_ready` = 1, some `req_valid` set: grant window; go to EXEC, back to back.
  - RESP, `rsp_ready` = 1, no `req_valid` set: go to IDLE.
- `ptr` advances only on a grant. Requesters not granted keep their position, which guarantees that any continuously asserted request is granted within `NUM_REQ` grants.
- Requester rules: `req_valid` and its operands stay stable until `req_ready`. The block does not depend on `req_valid` dropping without a grant; such a request is simply not serviced.
- Reset (`rst_n` = 0 at a rising edge), including mid-operation:
  - State goes to IDLE; `ptr` = 0.
  - Operand, sum and id registers are cleared; any in-flight result is discarded.
  - While `rst_n` = 0, `req_ready` = 0.

## Timing
- Reset values: `rsp_valid` = 0, `rsp_sum` = 0, `rsp_id` = 0, `req_ready` = 0.
- Latency: handshake at edge T (`req_valid[i]` & `req_ready[i]`) gives `rsp_valid` = 1 from T+2, with `rsp_sum` valid at the same time.
- Throughput: one result per 2 cycles when `rsp_ready` is held at 1 and requests are pending. The bound is the EXEC/RESP alternation.
- `req_ready` is a combinational function of state, `ptr`, `req_valid` and `rsp_ready`. It has no path from `req_a`/`req_b`.
- `rsp_*` outputs are driven from registers only.
- Simultaneous requests in a grant window: exactly one `req_ready` bit is high, chosen by `ptr`.
- A request arriving while the block is in EXEC is not granted before the next grant window.

## Test plan
- Reset and idle:
  - Hold `rst_n` = 0 for 3 cycles with all `req_valid` = 1 → `req_ready` = 0, `rsp_valid` = 0, `rsp_sum` = 0 throughout.
  - After release, the first grant goes to requester 0.
- Single add, requester 2 with A = `45'h1FFF_FFFF_FFFF` (2^45−1) and B = `41'h1FF_FFFF_FFFF` (2^41−1):
  - Handshake at T; at T+2, `rsp_valid` = 1, `rsp_id` = 2, `rsp_sum` = `46'h21FF_FFFF_FFFE`.
- Round-robin, all 4 requesters valid continuously, `rsp_ready` = 1:
  - Grant order 0,1,2,3,0,…; one `rsp_valid` pulse every 2 cycles; `rsp_id` follows the same order.
- Back-pressure:
  - Hold `rsp_ready` = 0 for 5 cycles in RESP with requester 1 pending → `rsp_sum`/`rsp_id` stay constant and `req_ready` = 0.
  - On the `rsp_ready` = 1 cycle, `req_ready[1]` = 1 in that same cycle.
- Fairness and pointer: requesters 0 and 3 always valid, `ptr` starting at 0 → grants alternate 0,3,0,3; requester 3 is never starved.
- Reset mid-operation: assert `rst_n` = 0 for one cycle during EXEC → no `rsp_valid` follows; the next grant goes to the lowest-index valid requester (`ptr` = 0).

Source files
------------

// File: rtl/adder45_rr_arbiter.sv
// adder45_rr_arbiter
//
// Shares one 45-bit + 41-bit unsigned adder between NUM_REQ requesters.
// Requests are granted round-robin. The winning operands are registered,
// summed in the following cycle, and returned with the requester index
// through a single-entry response buffer.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   [NUM_REQ]     per-requester operand-pair valid
//   req_a      in   [NUM_REQ*45]  operand A, requester i at [45*i +: 45]
//   req_b      in   [NUM_REQ*41]  operand B, requester i at [41*i +: 41]
//   req_ready  out  [NUM_REQ]     one-hot or zero, operands taken this cycle
//   rsp_valid  out  response holds a result
//   rsp_ready  in   consumer accepts the response
//   rsp_id     out  [ID_W]        owner of rsp_sum
//   rsp_sum    out  [46]          A + zero-extended B
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | nothing in flight, grant window open
// ST_EXEC   | operand registers loaded, sum registered at end of cycle
// ST_RESP   | rsp_valid high; grant window open when rsp_ready is high

module customAdder45_4 (
   input  logic [44:0] a_i,
   input  logic [40:0] b_i,
   output logic [45:0] sum_o
);
   assign sum_o = {1'b0, a_i} + {5'b0, b_i};
endmodule

module adder45_rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*45-1:0] req_a,
   input  logic [NUM_REQ*41-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [45:0]           rsp_sum
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [44:0]       op_a_q, op_a_d;
   logic [40:0]       op_b_q, op_b_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [45:0]       sum_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic [45:0]       adder_sum;

   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [ID_W-1:0]   cand_idx;
   logic              grant_window;
   logic              grant;

   // First valid requester at or after ptr, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!win_found && req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // rst_n gates the window so req_ready stays low while reset is held.
   assign grant_window = rst_n &&
                         ((state_q == ST_IDLE) ||
                          ((state_q == ST_RESP) && rsp_ready));
   assign grant        = grant_window && win_found;

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      ptr_d     = ptr_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      id_d      = id_q;
      if (grant) begin
         req_ready = NUM_REQ'(1) << win_idx;
         op_a_d    = req_a[45*win_idx +: 45];
         op_b_d    = req_b[41*win_idx +: 41];
         id_d      = win_idx;
         ptr_d     = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      end
      case (state_q)
         ST_IDLE: if (grant) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = grant ? ST_EXEC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   customAdder45_4 u_adder (
      .a_i   (op_a_q),
      .b_i   (op_b_q),
      .sum_o (adder_sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         id_q     <= '0;
         sum_q    <= '0;
         rsp_id_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         id_q    <= id_d;
         if (state_q == ST_EXEC) begin
            sum_q    <= adder_sum;
            rsp_id_q <= id_q;
         end
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_sum   = sum_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder45_rr_arbiter.sv
// Directed testbench for adder45_rr_arbiter with NUM_REQ = 4.
// Inputs change on the falling edge; outputs are checked 1 time unit later,
// well away from the rising edge.

module tb_adder45_rr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*45-1:0] req_a;
   logic [NUM_REQ*41-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [45:0]           rsp_sum;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   adder45_rr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge, then settle.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [44:0] a, input logic [40:0] b);
      req_a[45*i +: 45] = a;
      req_b[41*i +: 41] = b;
   endtask

   // Default operand set: A_i = 0x100*(i+1), B_i = i+1.
   function automatic logic [45:0] dflt_sum(input int i);
      return 46'(64'h100 * (i + 1) + (i + 1));
   endfunction

   task automatic load_default_ops();
      for (int i = 0; i < NUM_REQ; i++)
         set_ops(i, 45'(64'h100 * (i + 1)), 41'(i + 1));
   endtask

   logic [45:0] held_sum;
   int          fair_seq [4] = '{0, 3, 0, 3};

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      load_default_ops();

      // Reset held for 3 cycles with every request asserted.
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_req_ready", 64'(req_ready), 64'h0);
         chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
         chk("rst_rsp_sum",   64'(rsp_sum),   64'h0);
         chk("rst_rsp_id",    64'(rsp_id),    64'h0);
      end

      // Round-robin with all four valid and rsp_ready held high.
      rst_n = 1'b1;
      #1;
      for (int g = 0; g < 8; g++) begin
         chk($sformatf("rr_ready_g%0d", g), 64'(req_ready), 64'(1 << (g % 4)));
         if (g > 0) begin
            chk($sformatf("rr_valid_g%0d", g), 64'(rsp_valid), 64'h1);
            chk($sformatf("rr_id_g%0d", g),    64'(rsp_id),    64'((g - 1) % 4));
            chk($sformatf("rr_sum_g%0d", g),   64'(rsp_sum),   64'(dflt_sum((g - 1) % 4)));
         end
         step();
         chk($sformatf("rr_exec_valid_g%0d", g), 64'(rsp_valid), 64'h0);
         chk($sformatf("rr_exec_ready_g%0d", g), 64'(req_ready), 64'h0);
         step();
      end
      req_valid = '0;
      #1;
      chk("rr_last_valid", 64'(rsp_valid), 64'h1);
      chk("rr_last_id",    64'(rsp_id),    64'h3);
      chk("rr_last_ready", 64'(req_ready), 64'h0);
      step();
      chk("rr_idle_valid", 64'(rsp_valid), 64'h0);

      // Single add at the operand extremes from requester 2 (ptr is 0).
      set_ops(2, 45'h1FFF_FFFF_FFFF, 41'h1FF_FFFF_FFFF);
      req_valid = 4'b0100;
      #1;
      chk("max_ready", 64'(req_ready), 64'h4);
      step();
      req_valid = '0;
      chk("max_exec_valid", 64'(rsp_valid), 64'h0);
      step();
      chk("max_valid", 64'(rsp_valid), 64'h1);
      chk("max_id",    64'(rsp_id),    64'h2);
      chk("max_sum",   64'(rsp_sum),   64'h21FF_FFFF_FFFE);

      // Back-pressure for 5 cycles with requester 1 pending (ptr is 3).
      load_default_ops();
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      held_sum  = 46'h21FF_FFFF_FFFE;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp_ready_c%0d", c), 64'(req_ready), 64'h0);
         chk($sformatf("bp_valid_c%0d", c), 64'(rsp_valid), 64'h1);
         chk($sformatf("bp_sum_c%0d", c),   64'(rsp_sum),   64'(held_sum));
         chk($sformatf("bp_id_c%0d", c),    64'(rsp_id),    64'h2);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(req_ready), 64'h2);
      step();
      req_valid = '0;
      step();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("bp_rsp_id",    64'(rsp_id),    64'h1);
      chk("bp_rsp_sum",   64'(rsp_sum),   64'(dflt_sum(1)));
      step();
      chk("bp_idle_valid", 64'(rsp_valid), 64'h0);

      // Fairness between requesters 0 and 3 from ptr = 0.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_valid = 4'b1001;
      #1;
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("fair_ready_g%0d", g), 64'(req_ready), 64'(1 << fair_seq[g]));
         step();
         step();
         chk($sformatf("fair_id_g%0d", g),  64'(rsp_id),  64'(fair_seq[g]));
         chk($sformatf("fair_sum_g%0d", g), 64'(rsp_sum), 64'(dflt_sum(fair_seq[g])));
      end

      // Reset during EXEC: the in-flight result is dropped and ptr returns to 0.
      chk("mid_grant_ready", 64'(req_ready), 64'h1);
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'h0);
      step();
      rst_n     = 1'b1;
      req_valid = '0;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("mid_valid_c%0d", c), 64'(rsp_valid), 64'h0);
         chk($sformatf("mid_sum_c%0d", c),   64'(rsp_sum),   64'h0);
         step();
      end
      req_valid = 4'b1001;
      #1;
      chk("mid_next_grant", 64'(req_ready), 64'h1);
      step();
      step();
      chk("mid_next_id",  64'(rsp_id),  64'h0);
      chk("mid_next_sum", 64'(rsp_sum), 64'(dflt_sum(0)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
